jtag_debug_cmd_sync: RTL and testbench
======================================

// Module: jtag_debug_cmd_sync
// PURPOSE
//  System-clock side of the Nios II JTAG debug path, parametrised over IR/DR width and sync depth.
//  Synchronises the virtual-JTAG update strobes (UIR/UDR) from the TCK domain, latches IR and DR.
//  Decodes each update into one-cycle take_action/take_no_action pulses per IR code.
//  Adds a one-entry command hold with ready handshake and a sticky overrun flag.
// PARAMETERS
//  IR_WIDTH     2   virtual IR width; NUM_CMDS = 2**IR_WIDTH decode channels
//  DR_WIDTH     38  shift-register / jdo width
//  ACTION_BIT   34  sr bit that selects take_action (1) vs take_no_action (0); must be < DR_WIDTH
//  SYNC_STAGES  2   synchroniser flops on vs_uir/vs_udr; legal range 2..4
//  CNT_WIDTH    16  width of issued-command counter
// PORTS
//  clk            in   1                system clock
//  reset          in   1                asynchronous active-high reset
//  ir_in          in   IR_WIDTH         TCK-domain IR; stable while vs_uir high and until next UIR
//  sr             in   DR_WIDTH         TCK-domain shift register; stable from UDR until next SDR
//  vs_uir         in   1                TCK-domain update-IR level strobe (async to clk)
//  vs_udr         in   1                TCK-domain update-DR level strobe (async to clk)
//  cmd_ready      in   1                consumer can accept a decoded command this cycle
//  overrun_clr    in   1                clears overrun (sync, one cycle)
//  jdo            out  DR_WIDTH         DR value captured at the accepted UDR
//  ir_latched     out  IR_WIDTH         IR captured at the last UIR
//  take_action    out  2**IR_WIDTH      one-hot pulse, bit = IR code, when sr[ACTION_BIT]=1
//  take_no_action out  2**IR_WIDTH      one-hot pulse, bit = IR code, when sr[ACTION_BIT]=0
//  cmd_pending    out  1                a captured command is waiting for cmd_ready
//  overrun        out  1                sticky: a UDR arrived while a command was pending
//  cmd_count      out  CNT_WIDTH        number of pulses issued, wraps modulo 2**CNT_WIDTH
// BEHAVIOUR
//  Reset: all outputs 0; sync chains, edge registers and FSM cleared (IDLE). Async assert, sync release.
//  Sync: vs_uir, vs_udr each pass SYNC_STAGES flops; rising edge = sync_out & ~sync_out_d.
//  UIR edge: ir_latched <= ir_in on that edge. No other effect.
//  FSM IDLE: on UDR edge, jdo <= sr, cmd_ir <= ir_latched (pre-update value), cmd_act <= sr[ACTION_BIT].
//   Then -> PEND.
//  FSM PEND: cmd_pending=1. If cmd_ready=1 -> ISSUE; else hold.
//  FSM ISSUE: exactly one of take_action[cmd_ir] / take_no_action[cmd_ir] high this cycle only.
//   cmd_count++; -> IDLE. Pulse outputs are registered, never combinational.
//  Latency: edge E0 first samples vs_udr=1; capture at edge E0+SYNC_STAGES+1.
//   With cmd_ready=1, the pulse is high for the single cycle after edge E0+SYNC_STAGES+2.
//  UDR edge in PEND or ISSUE: command dropped, jdo unchanged, overrun <= 1.
//  overrun_clr and a new overrun in the same cycle: overrun stays 1 (set wins).
//  UIR and UDR edges in the same cycle: the UDR uses the old ir_latched; the new IR applies to the next UDR.
//  cmd_ready deasserted in PEND holds indefinitely; jdo stays stable until the next accepted capture.
//  vs_udr held high for many clks yields one edge only; re-arm requires the sync output to return 0.
//  Reset mid-PEND/ISSUE: pending command discarded, no pulse emitted after reset release.
//  cmd_count wraps from all-ones to 0 without flag.
// TESTING
//  1 reset, ir_in=2 + UIR, sr[34]=1 sr=38'h5_0000_1234 + UDR, ready=1
//    -> take_action=4'b0100 for one cycle at E0+4 (SYNC_STAGES=2); jdo=sr; count=1.
//  2 ir=0, sr[34]=0, ready=0 for 10 cycles then 1
//    -> cmd_pending=1 throughout, no pulse; take_no_action=4'b0001 one cycle after ready rises.
//  3 second UDR while pending (ready=0)
//    -> overrun=1, jdo keeps first value, single pulse later.
//    -> overrun_clr with no new UDR returns overrun to 0.
//  4 UIR(ir=3) and UDR coincident after prior ir=1
//    -> pulse on bit 1; next UDR pulses bit 3.
//  5 reset asserted in PEND -> all outputs 0 immediately; no pulse after release.
//  6 CNT_WIDTH=4, issue 17 commands -> cmd_count=1; repeat 1-4 with IR_WIDTH=3, DR_WIDTH=44, SYNC_STAGES=3.

Source files
------------

// File: rtl/jtag_debug_cmd_sync.sv
// jtag_debug_cmd_sync: system-clock side of the JTAG debug command path.
// Brings the TCK-domain update-IR/update-DR strobes across, latches IR and
// DR, and turns each accepted DR update into a single registered pulse on
// take_action / take_no_action. A one-entry hold waits for cmd_ready, and a
// sticky overrun flag records updates that arrive while that entry is busy.
module jtag_debug_cmd_sync #(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned ACTION_BIT  = 34,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IR_WIDTH-1:0]      ir_in,
  input  logic [DR_WIDTH-1:0]      sr,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic                     cmd_ready,
  input  logic                     overrun_clr,
  output logic [DR_WIDTH-1:0]      jdo,
  output logic [IR_WIDTH-1:0]      ir_latched,
  output logic [2**IR_WIDTH-1:0]   take_action,
  output logic [2**IR_WIDTH-1:0]   take_no_action,
  output logic                     cmd_pending,
  output logic                     overrun,
  output logic [CNT_WIDTH-1:0]     cmd_count
);

  localparam int unsigned NUM_CMDS = 2**IR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]             rst_pipe;
  logic                   rst_int;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_d;
  logic                   udr_d;
  logic                   uir_edge;
  logic                   udr_edge;
  logic [1:0]             state;
  logic [IR_WIDTH-1:0]    cmd_ir;
  logic                   cmd_act;
  logic [NUM_CMDS-1:0]    cmd_onehot;

  // Reset bridge: assert immediately, release two clocks after reset drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= '1;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  // Strobe synchronisers and registered rising-edge detection.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_d    <= 1'b0;
      udr_d    <= 1'b0;
      uir_edge <= 1'b0;
      udr_edge <= 1'b0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_d    <= uir_sync[SYNC_STAGES-1];
      udr_d    <= udr_sync[SYNC_STAGES-1];
      uir_edge <= uir_sync[SYNC_STAGES-1] & ~uir_d;
      udr_edge <= udr_sync[SYNC_STAGES-1] & ~udr_d;
    end
  end

  // IR latch; a coincident DR capture still sees the previous value.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int)       ir_latched <= '0;
    else if (uir_edge) ir_latched <= ir_in;
  end

  // One-hot decode of the held command's IR code.
  always_comb begin
    cmd_onehot         = '0;
    cmd_onehot[cmd_ir] = 1'b1;
  end

  // Command hold FSM: capture, wait for ready, emit one registered pulse.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state          <= ST_IDLE;
      jdo            <= '0;
      cmd_ir         <= '0;
      cmd_act        <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
      cmd_count      <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      case (state)
        ST_IDLE: begin
          if (udr_edge) begin
            jdo     <= sr;
            cmd_ir  <= ir_latched;
            cmd_act <= sr[ACTION_BIT];
            state   <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (cmd_ready) begin
            if (cmd_act) take_action    <= cmd_onehot;
            else         take_no_action <= cmd_onehot;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cmd_count <= cmd_count + CNT_WIDTH'(1);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overrun; a new overrun takes priority over a clear.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int)                          overrun <= 1'b0;
    else if (udr_edge && state != ST_IDLE) overrun <= 1'b1;
    else if (overrun_clr)                 overrun <= 1'b0;
  end

  assign cmd_pending = (state == ST_PEND);

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Bench for jtag_debug_cmd_sync: two instances (default widths, and a wider
// 3-stage-sync variant with a 4-bit counter) share one stimulus stream and
// are compared every cycle against an event-level reference model.
module tb_jtag_debug_cmd_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  ir_in = '0;
  logic [43:0] sr = '0;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        overrun_clr = 1'b0;

  logic [37:0] jdo0;
  logic [1:0]  irl0;
  logic [3:0]  ta0, tna0;
  logic        pend0, ovr0;
  logic [15:0] cnt0;

  logic [43:0] jdo1;
  logic [2:0]  irl1;
  logic [7:0]  ta1, tna1;
  logic        pend1, ovr1;
  logic [3:0]  cnt1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          chk_en = 1'b0;
  bit          rand_en = 1'b0;

  always #5 clk = ~clk;

  jtag_debug_cmd_sync #(
    .IR_WIDTH(2), .DR_WIDTH(38), .ACTION_BIT(34), .SYNC_STAGES(2), .CNT_WIDTH(16)
  ) dut0 (
    .clk(clk), .reset(reset), .ir_in(ir_in[1:0]), .sr(sr[37:0]),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(jdo0), .ir_latched(irl0), .take_action(ta0), .take_no_action(tna0),
    .cmd_pending(pend0), .overrun(ovr0), .cmd_count(cnt0)
  );

  jtag_debug_cmd_sync #(
    .IR_WIDTH(3), .DR_WIDTH(44), .ACTION_BIT(34), .SYNC_STAGES(3), .CNT_WIDTH(4)
  ) dut1 (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
    .jdo(jdo1), .ir_latched(irl1), .take_action(ta1), .take_no_action(tna1),
    .cmd_pending(pend1), .overrun(ovr1), .cmd_count(cnt1)
  );

  // Reference model: a strobe edge becomes visible SYNC_STAGES+1 clocks after
  // it is first sampled; the command slot is idle / waiting / pulsing.
  bit          uh[2][8];
  bit          ih[2][8];
  logic [43:0] m_jdo[2];
  int          m_irl[2], m_cir[2], m_cnt[2];
  bit          m_act[2], m_pend[2], m_issue[2], m_ovr[2];

  task automatic model_clear(int k);
    for (int j = 0; j < 8; j++) begin uh[k][j] = 0; ih[k][j] = 0; end
    m_jdo[k] = '0; m_irl[k] = 0; m_cir[k] = 0; m_cnt[k] = 0;
    m_act[k] = 0; m_pend[k] = 0; m_issue[k] = 0; m_ovr[k] = 0;
  endtask

  task automatic model_step(int k);
    int lat  = (k == 0) ? 3 : 4;
    int irm  = (k == 0) ? 3 : 7;
    int cmsk = (k == 0) ? 65535 : 15;
    logic [43:0] dmsk = (k == 0) ? 44'h03F_FFFF_FFFF : 44'hFFF_FFFF_FFFF;
    bit ue, ie, busy;
    for (int j = 7; j > 0; j--) begin uh[k][j] = uh[k][j-1]; ih[k][j] = ih[k][j-1]; end
    uh[k][0] = vs_udr;
    ih[k][0] = vs_uir;
    ue   = uh[k][lat] && !uh[k][lat+1];
    ie   = ih[k][lat] && !ih[k][lat+1];
    busy = m_pend[k] || m_issue[k];
    if (ue && busy)   m_ovr[k] = 1;
    else if (overrun_clr) m_ovr[k] = 0;
    if (m_issue[k]) begin
      m_issue[k] = 0;
      m_cnt[k]   = (m_cnt[k] + 1) & cmsk;
    end else if (m_pend[k]) begin
      if (cmd_ready) begin m_pend[k] = 0; m_issue[k] = 1; end
    end else if (ue) begin
      m_jdo[k]  = sr & dmsk;
      m_cir[k]  = m_irl[k];
      m_act[k]  = sr[34];
      m_pend[k] = 1;
    end
    if (ie) m_irl[k] = int'(ir_in) & irm;
  endtask

  always @(posedge clk) begin
    if (reset) begin model_clear(0); model_clear(1); end
    else begin model_step(0); model_step(1); end
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_pulse(int k, bit act);
    if (reset || !m_issue[k] || m_act[k] != act) return '0;
    return 64'd1 << m_cir[k];
  endfunction

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("jdo0",  64'(jdo0),  reset ? '0 : 64'(m_jdo[0]));
      check("irl0",  64'(irl0),  reset ? '0 : 64'(m_irl[0]));
      check("ta0",   64'(ta0),   exp_pulse(0, 1));
      check("tna0",  64'(tna0),  exp_pulse(0, 0));
      check("pend0", 64'(pend0), reset ? '0 : 64'(m_pend[0]));
      check("ovr0",  64'(ovr0),  reset ? '0 : 64'(m_ovr[0]));
      check("cnt0",  64'(cnt0),  reset ? '0 : 64'(m_cnt[0]));
      check("jdo1",  64'(jdo1),  reset ? '0 : 64'(m_jdo[1]));
      check("irl1",  64'(irl1),  reset ? '0 : 64'(m_irl[1]));
      check("ta1",   64'(ta1),   exp_pulse(1, 1));
      check("tna1",  64'(tna1),  exp_pulse(1, 0));
      check("pend1", 64'(pend1), reset ? '0 : 64'(m_pend[1]));
      check("ovr1",  64'(ovr1),  reset ? '0 : 64'(m_ovr[1]));
      check("cnt1",  64'(cnt1),  reset ? '0 : 64'(m_cnt[1]));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_uir(logic [2:0] v);
    ir_in = v; vs_uir = 1'b1; cyc(6);
    vs_uir = 1'b0; cyc(8);
  endtask

  task automatic do_udr(logic [43:0] v, int hold);
    sr = v; vs_udr = 1'b1; cyc(hold);
    vs_udr = 1'b0; cyc(8);
  endtask

  function automatic logic [43:0] rnd_dr();
    return {12'($urandom), 32'($urandom)};
  endfunction

  task automatic do_reset();
    reset = 1'b1; cyc(3);
    reset = 1'b0; cyc(4);
  endtask

  // Random ready / overrun_clr activity during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) begin
        cmd_ready   = ($urandom_range(0, 2) != 0);
        overrun_clr = ($urandom_range(0, 7) == 0);
      end
    end
  end

  initial begin
    logic [43:0] a, b;
    chk_en = 1'b1;
    do_reset();

    // Basic action command on IR code 2.
    cmd_ready = 1'b1;
    do_uir(3'd2);
    do_udr(44'h5_0000_1234, 4);
    check("t1_jdo0", 64'(jdo0), 64'h5_0000_1234);
    check("t1_cnt0", 64'(cnt0), 64'd1);
    check("t1_cnt1", 64'(cnt1), 64'd1);

    // No-action command held back by cmd_ready.
    cmd_ready = 1'b0;
    do_uir(3'd0);
    a = rnd_dr(); a[34] = 1'b0;
    do_udr(a, 4);
    cyc(10);
    check("t2_pend0", 64'(pend0), 64'd1);
    check("t2_pend1", 64'(pend1), 64'd1);
    cmd_ready = 1'b1;
    cyc(6);

    // Second update while pending, then clear the sticky flag.
    cmd_ready = 1'b0;
    a = rnd_dr(); b = rnd_dr();
    do_udr(a, 3);
    do_udr(b, 3);
    check("t3_jdo0", 64'(jdo0), 64'(a[37:0]));
    check("t3_jdo1", 64'(jdo1), 64'(a));
    check("t3_ovr0", 64'(ovr0), 64'd1);
    cmd_ready = 1'b1;
    cyc(6);
    overrun_clr = 1'b1; cyc(1);
    overrun_clr = 1'b0; cyc(1);
    check("t3_clr0", 64'(ovr0), 64'd0);
    check("t3_clr1", 64'(ovr1), 64'd0);

    // Coincident IR and DR updates.
    do_uir(3'd1);
    ir_in = 3'd3; sr = rnd_dr(); vs_uir = 1'b1; vs_udr = 1'b1; cyc(4);
    vs_uir = 1'b0; vs_udr = 1'b0; cyc(10);
    check("t4_irl0", 64'(irl0), 64'd3);
    check("t4_irl1", 64'(irl1), 64'd3);
    do_udr(rnd_dr(), 4);

    // Reset while a command is pending.
    cmd_ready = 1'b0;
    do_udr(rnd_dr(), 4);
    check("t5_pend0", 64'(pend0), 64'd1);
    reset = 1'b1; #2;
    check("t5_rpend0", 64'(pend0), 64'd0);
    check("t5_rjdo1", 64'(jdo1), 64'd0);
    cyc(3);
    reset = 1'b0; cmd_ready = 1'b1;
    cyc(20);

    // Counter wrap on the 4-bit instance, then a long held strobe.
    do_reset();
    for (int i = 0; i < 17; i++) do_udr(rnd_dr(), 2);
    check("t6_cnt0", 64'(cnt0), 64'd17);
    check("t6_cnt1", 64'(cnt1), 64'd1);
    do_udr(rnd_dr(), 30);
    check("t7_cnt0", 64'(cnt0), 64'd18);
    check("t7_cnt1", 64'(cnt1), 64'd2);

    // Random phase.
    rand_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          ir_in = 3'($urandom); vs_uir = 1'b1; cyc($urandom_range(1, 5));
          vs_uir = 1'b0; cyc($urandom_range(1, 8));
        end
        1, 2: begin
          sr = rnd_dr(); vs_udr = 1'b1; cyc($urandom_range(1, 6));
          vs_udr = 1'b0; cyc($urandom_range(1, 8));
        end
        default: begin
          ir_in = 3'($urandom); sr = rnd_dr();
          vs_uir = 1'b1; vs_udr = 1'b1; cyc($urandom_range(1, 4));
          vs_uir = 1'b0; vs_udr = 1'b0; cyc($urandom_range(1, 8));
        end
      endcase
    end
    rand_en = 1'b0;
    cmd_ready = 1'b1; overrun_clr = 1'b0;
    cyc(30);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
